// File: rtl/switch_input_controller_if.sv
// switch_input_controller_if: valid/ready word stream from the switch FIFO to the core
interface switch_input_controller_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  modport master (output in_valid, output in_data, input in_ready);
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/switch_input_controller.sv
// switch_input_controller: debounced check-in button capturing switch words into a FWFT FIFO
module switch_input_controller #(
  parameter int DATA_W          = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             Button,
  input  logic [DATA_W-1:0]                Switches,
  input  logic                             clr_overflow,
  output logic                             press_pulse,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow,
  switch_input_controller_if.master        bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [NW-1:0] LAST = NW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, PRESS_CNT, PRESSED, HELD, REL_CNT} state_t;
  state_t            state, state_nx;
  logic [NW-1:0]     cnt, cnt_nx;
  logic              sync1, sync2, btn;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              full, pop, wr_en, drop;
  // two-flop synchroniser; reset value means released
  always_ff @(posedge Clock)
    if (Reset) {sync1, sync2} <= 2'b11;
    else {sync1, sync2} <= {Button, sync1};
  assign btn = ~sync2;
  // debounce state and stability counter
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // debounce transitions; counter stays zero unless counting within the same state
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      IDLE:      state_nx = btn ? PRESS_CNT : IDLE;
      PRESS_CNT: if (!btn) state_nx = IDLE;
                 else if (cnt == LAST) state_nx = PRESSED;
                 else cnt_nx = cnt + 1'b1;
      PRESSED:   state_nx = HELD;
      HELD:      state_nx = btn ? HELD : REL_CNT;
      REL_CNT:   if (btn) state_nx = HELD;
                 else if (cnt == LAST) state_nx = IDLE;
                 else cnt_nx = cnt + 1'b1;
      default:   state_nx = IDLE;
    endcase
  end
  // one-cycle strobe per accepted press
  always_comb press_pulse = (state == PRESSED);
  assign full  = (fifo_count == FULL);
  assign pop   = bus.in_valid && bus.in_ready;
  assign wr_en = press_pulse && (!full || pop);
  assign drop  = press_pulse && full && !pop;
  assign bus.in_valid = (fifo_count != '0);
  assign bus.in_data  = bus.in_valid ? mem[rd_ptr] : '0;
  // storage is not reset; empty FIFO masks its contents
  always_ff @(posedge Clock)
    if (wr_en) mem[wr_ptr] <= Switches;
  // pointers wrap naturally since depth is a power of two; a drop outranks a clear
  always_ff @(posedge Clock)
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
      overflow   <= drop | (overflow & ~clr_overflow);
    end
endmodule

// File: tb/tb_switch_input_controller.sv
// tb_switch_input_controller: random and directed stimulus against a run-length debounce model
module tb_switch_input_controller;
  localparam int D = 4;
  localparam int DEPTH = 4;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Button = 1'b1;
  logic [15:0] Switches = '0;
  logic        clr_overflow = 1'b0;
  logic        press_pulse, overflow;
  logic [2:0]  fifo_count;
  int n_chk = 0, n_fail = 0;
  bit m_s1 = 1, m_s2 = 1, m_level = 0, m_pend = 0, m_ovf = 0;
  int m_run = 0;
  logic [15:0] q[$];
  switch_input_controller_if #(.DATA_W(16)) bus ();
  switch_input_controller #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(D)) dut (
    .Clock(Clock), .Reset(Reset), .Button(Button), .Switches(Switches),
    .clr_overflow(clr_overflow), .press_pulse(press_pulse), .fifo_count(fifo_count),
    .overflow(overflow), .bus(bus.master)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    bit b, popm, dropm;
    @(posedge Clock);
    if (Reset) begin
      m_s1 = 1; m_s2 = 1; m_level = 0; m_run = 0; m_pend = 0; m_ovf = 0;
      q.delete();
    end else begin
      b = ~m_s2;
      popm = (q.size() != 0) && bus.in_ready;
      dropm = m_pend && (q.size() == DEPTH) && !popm;
      if (popm) void'(q.pop_front());
      if (m_pend && !dropm) q.push_back(Switches);
      m_ovf = dropm ? 1'b1 : clr_overflow ? 1'b0 : m_ovf;
      if (m_pend) begin
        m_pend = 0; m_level = 1; m_run = 0;
      end else if (b != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_run = 0;
          if (!m_level) m_pend = 1;
          else m_level = 0;
        end
      end else m_run = 0;
      m_s2 = m_s1; m_s1 = Button;
    end
    #1;
    chk("pulse", press_pulse, m_pend);
    chk("valid", bus.in_valid, q.size() != 0);
    chk("data", bus.in_data, q.size() != 0 ? q[0] : 16'h0);
    chk("count", fifo_count, q.size());
    chk("ovf", overflow, m_ovf);
  endtask
  task automatic press(input logic [15:0] sw);
    Switches = sw; Button = 1'b0;
    repeat (9) step();
    Button = 1'b1;
    repeat (9) step();
  endtask
  task automatic hold_to_pulse(input logic [15:0] sw);
    bit seen = 0;
    Switches = sw; Button = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = press_pulse;
    end
    chk("pulse_seen", seen, 1);
  endtask
  initial begin
    int first, pulses;
    bus.in_ready = 1'b0;
    repeat (2) step();
    Reset = 1'b0;
    repeat (3) step();
    Switches = 16'h00A5; Button = 1'b0; first = -1; pulses = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (press_pulse) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    chk("first_pulse_edge", first, 6);
    chk("pulse_count", pulses, 1);
    chk("head_a5", bus.in_data, 16'h00A5);
    Button = 1'b1; repeat (9) step();
    bus.in_ready = 1'b1; step(); bus.in_ready = 1'b0;
    pulses = 0;
    for (int r = 0; r < 5; r++) begin
      Button = 1'b0; repeat (3) begin step(); pulses += press_pulse; end
      Button = 1'b1; repeat (2) begin step(); pulses += press_pulse; end
    end
    repeat (8) begin step(); pulses += press_pulse; end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_count", fifo_count, 0);
    for (int i = 1; i <= 5; i++) press(16'(i));
    chk("fill_count", fifo_count, 4);
    chk("fill_ovf", overflow, 1);
    bus.in_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", bus.in_data, i);
      step();
    end
    chk("drain_valid", bus.in_valid, 0);
    chk("drain_data", bus.in_data, 0);
    bus.in_ready = 1'b0;
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);
    for (int i = 1; i <= 4; i++) press(16'(i));
    hold_to_pulse(16'h0009);
    bus.in_ready = 1'b1; step(); bus.in_ready = 1'b0;
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_head", bus.in_data, 2);
    Button = 1'b1; repeat (9) step();
    bus.in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tail_order", bus.in_data, i < 3 ? i + 2 : 9);
      step();
    end
    bus.in_ready = 1'b0;
    for (int i = 1; i <= 5; i++) press(16'(i + 16));
    chk("drop_ovf", overflow, 1);
    hold_to_pulse(16'h0077);
    clr_overflow = 1'b1; step();
    chk("set_beats_clear", overflow, 1);
    step(); clr_overflow = 1'b0;
    chk("clear_after", overflow, 0);
    Button = 1'b0; Reset = 1'b1;
    repeat (3) begin
      step();
      chk("rst_zero", {press_pulse, bus.in_valid, bus.in_data, fifo_count, overflow}, 0);
    end
    Reset = 1'b0; first = -1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (press_pulse && first < 0) first = e;
    end
    chk("post_reset_pulse_edge", first, 6);
    Button = 1'b1; repeat (9) step();
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 39) == 0);
      Button = ~Button;
      Switches = 16'($urandom);
      repeat ($urandom_range(1, 12)) begin
        bus.in_ready = ($urandom_range(0, 3) == 0);
        clr_overflow = ($urandom_range(0, 7) == 0);
        step();
        Reset = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
